// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if
// Control bundle between the pipeline stall/flush sequencer and the rest of
// the core: hazard/redirect/interrupt inputs toward the sequencer, stage
// enable/flush controls and performance counters back out.
// master: the core side (drives the event inputs, consumes the controls).
// slave : the sequencer itself.
interface pipeline_stall_ctrl_if;
  // Event inputs to the sequencer
  logic        LW_Stall;
  logic        Branch_EX;
  logic        Jump_ID;
  logic        MulDiv_Start;
  logic        IRQ;
  logic        IRQ_Enable;
  // Pipeline register controls from the sequencer
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        ID_EX_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        EX_MEM_Bubble;
  logic        Exc_Redirect;
  logic        IRQ_Ack;
  logic        MulDiv_Busy;
  logic        MulDiv_Done;
  // Performance counters
  logic [31:0] Stall_Cycles;
  logic [31:0] Flush_Events;

  modport master (
    output LW_Stall, Branch_EX, Jump_ID, MulDiv_Start, IRQ, IRQ_Enable,
    input  PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
    input  EX_MEM_Bubble, Exc_Redirect, IRQ_Ack, MulDiv_Busy, MulDiv_Done,
    input  Stall_Cycles, Flush_Events
  );

  modport slave (
    input  LW_Stall, Branch_EX, Jump_ID, MulDiv_Start, IRQ, IRQ_Enable,
    output PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
    output EX_MEM_Bubble, Exc_Redirect, IRQ_Ack, MulDiv_Busy, MulDiv_Done,
    output Stall_Cycles, Flush_Events
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use
// stalls, branch/jump redirects, multi-cycle mul/div holds and interrupt
// entry with a single priority order. Controls are combinational from the
// FSM state and the current inputs so stalls act in the same cycle.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall-cycle and
// flush-event counters; without it both counter ports are tied to zero.
module pipeline_stall_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4,  // EX occupancy of a mul/div op (2..255)
  parameter int unsigned CNT_W         = 8   // countdown counter width
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_stall_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  // Counter value loaded on a mul/div start: the start cycle itself is the
  // first held cycle, so the remaining count is one less than the occupancy.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_irq_pend;
  logic             w_irq_pend_nxt;

  logic w_pc_write;
  logic w_if_id_write;
  logic w_id_ex_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_bubble;
  logic w_exc_redirect;
  logic w_irq_ack;
  logic w_muldiv_busy;
  logic w_muldiv_done;

  // Next-state, counter and control-output decode with reset override
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_id_ex_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_exc_redirect  = 1'b0;
    w_irq_ack       = 1'b0;
    w_muldiv_busy   = 1'b0;
    w_muldiv_done   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.MulDiv_Start) begin
          // Freeze the front end and hold the op in EX
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_id_ex_write   = 1'b0;
          w_ex_mem_bubble = 1'b1;
          w_muldiv_busy   = 1'b1;
          w_cnt_nxt       = CNT_LOAD;
          w_state_nxt     = ST_MD_BUSY;
        end else if (bus.Branch_EX) begin
          // Taken branch squashes both younger instructions
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (bus.LW_Stall) begin
          // Hold PC and IF/ID, inject one bubble into EX
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
        end else if (bus.Jump_ID) begin
          w_if_id_flush = 1'b1;
        end else if (r_irq_pend) begin
          // Interrupt entry only when no other event competes this cycle
          w_if_id_flush  = 1'b1;
          w_id_ex_flush  = 1'b1;
          w_exc_redirect = 1'b1;
          w_irq_ack      = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_MD_BUSY: begin
        if (r_cnt > CNT_ONE) begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_id_ex_write   = 1'b0;
          w_ex_mem_bubble = 1'b1;
          w_muldiv_busy   = 1'b1;
          w_cnt_nxt       = r_cnt - CNT_ONE;
        end else begin
          // Release cycle (a zero count is unreachable and also releases)
          w_muldiv_done = 1'b1;
          w_cnt_nxt     = CNT_ZERO;
          w_state_nxt   = ST_RUN;
        end
      end

      default: begin
        w_cnt_nxt   = CNT_ZERO;
        w_state_nxt = ST_RUN;
      end
    endcase

    if (reset) begin
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_id_ex_write   = 1'b0;
      w_if_id_flush   = 1'b1;
      w_id_ex_flush   = 1'b1;
      w_ex_mem_bubble = 1'b1;
      w_exc_redirect  = 1'b0;
      w_irq_ack       = 1'b0;
      w_muldiv_busy   = 1'b0;
      w_muldiv_done   = 1'b0;
    end else begin
      w_muldiv_done = w_muldiv_done;
    end

    // Acknowledge wins over a same-cycle request so one IRQ level is
    // not taken twice back to back.
    if (w_irq_ack) begin
      w_irq_pend_nxt = 1'b0;
    end else begin
      w_irq_pend_nxt = r_irq_pend | (bus.IRQ & bus.IRQ_Enable);
    end
  end

  // FSM state, mul/div countdown and pending-interrupt latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_cnt      <= CNT_ZERO;
      r_irq_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_irq_pend <= w_irq_pend_nxt;
    end
  end

  assign bus.PC_Write      = w_pc_write;
  assign bus.IF_ID_Write   = w_if_id_write;
  assign bus.ID_EX_Write   = w_id_ex_write;
  assign bus.IF_ID_Flush   = w_if_id_flush;
  assign bus.ID_EX_Flush   = w_id_ex_flush;
  assign bus.EX_MEM_Bubble = w_ex_mem_bubble;
  assign bus.Exc_Redirect  = w_exc_redirect;
  assign bus.IRQ_Ack       = w_irq_ack;
  assign bus.MulDiv_Busy   = w_muldiv_busy;
  assign bus.MulDiv_Done   = w_muldiv_done;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  // Saturating counters of stalled-PC cycles and flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (!w_pc_write && (r_stall_cycles != PERF_MAX)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if ((w_if_id_flush || w_id_ex_flush) && (r_flush_events != PERF_MAX)) begin
        r_flush_events <= r_flush_events + 32'd1;
      end else begin
        r_flush_events <= r_flush_events;
      end
    end
  end

  assign bus.Stall_Cycles = r_stall_cycles;
  assign bus.Flush_Events = r_flush_events;
`else
  assign bus.Stall_Cycles = 32'd0;
  assign bus.Flush_Events = 32'd0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Consumes the load-use stall from the data hazard unit, branch/jump redirects and multi-cycle mul/div issue, and latches external interrupts.
- Drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM, with one priority order that resolves simultaneous events.
- Contains a small FSM and a countdown counter that hold a mul/div operation in EX for a fixed number of cycles.

Parameters:
MULDIV_CYCLES, 4, total cycles a mul/div instruction occupies EX (legal range 2..255)
CNT_W, 8, width of the mul/div countdown counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
LW_Stall  input  1  load-use hazard from the hazard unit (combinational, same cycle)
Branch_EX  input  1  branch resolved taken in EX this cycle
Jump_ID  input  1  jump decoded in ID this cycle
MulDiv_Start  input  1  EX holds a mul/div op; may stay high while the op is held
IRQ  input  1  external interrupt request, level
IRQ_Enable  input  1  global interrupt enable
PC_Write  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register enable
ID_EX_Write  output  1  ID/EX register enable
IF_ID_Flush  output  1  clear IF/ID to NOP
ID_EX_Flush  output  1  clear ID/EX to NOP
EX_MEM_Bubble  output  1  load NOP into EX/MEM
Exc_Redirect  output  1  select exception vector for next PC
IRQ_Ack  output  1  one-cycle interrupt acceptance pulse
MulDiv_Busy  output  1  mul/div op being held in EX
MulDiv_Done  output  1  release cycle of a mul/div op
Stall_Cycles  output  32  performance counter (see Optional Feature)
Flush_Events  output  32  performance counter (see Optional Feature)

Behaviour:
- FSM states: RUN, MD_BUSY. Registers: state, cnt[CNT_W-1:0], irq_pend.
- Reset state: state=RUN, cnt=0, irq_pend=0. Reset mid-MD_BUSY aborts the op; RUN on the next cycle.
- Outputs are combinational from state and inputs, so stalls take effect in the same cycle.
- Default output values: all *_Write=1, all flush/bubble/status outputs=0.
- While reset is high, outputs are forced to:
  - PC_Write=IF_ID_Write=ID_EX_Write=0.
  - IF_ID_Flush=ID_EX_Flush=EX_MEM_Bubble=1.
  - All other outputs 0.
- irq_pend is set on any cycle with IRQ&IRQ_Enable, including MD_BUSY. It is cleared on the IRQ_Ack cycle and is not re-set by that same cycle's IRQ.
- RUN priority, highest first:
  1. MulDiv_Start: PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Bubble=1, MulDiv_Busy=1; cnt<=MULDIV_CYCLES-1; next state MD_BUSY.
  2. Branch_EX: IF_ID_Flush=1, ID_EX_Flush=1; PC writes the target; LW_Stall and Jump_ID are ignored.
  3. LW_Stall: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 (exactly one bubble per assertion); Jump_ID is ignored.
  4. Jump_ID: IF_ID_Flush=1.
  5. irq_pend: IF_ID_Flush=1, ID_EX_Flush=1, Exc_Redirect=1, IRQ_Ack=1.
- MulDiv_Start and Branch_EX are mutually exclusive by decode. If both are driven, MulDiv_Start wins.
- In MD_BUSY, all control inputs except reset are ignored; irq_pend still latches.
  - cnt != 1: hold (same outputs as RUN item 1); cnt<=cnt-1.
  - cnt == 1: release; default outputs plus MulDiv_Done=1; next state RUN.
- Resulting occupancy: the mul/div op stays in EX for exactly MULDIV_CYCLES cycles, with MULDIV_CYCLES-1 bubbles into MEM.
- MulDiv_Start still high on the release cycle is not a new start.
- A pending IRQ is taken no earlier than the first RUN cycle after release.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Stall_Cycles increments on each non-reset cycle with PC_Write=0.
  - Flush_Events increments on each non-reset cycle with IF_ID_Flush=1 or ID_EX_Flush=1.
  - Both reset to 0 and saturate at 32'hFFFFFFFF (no wrap).
- Not defined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- LW_Stall=1 for one cycle in RUN -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle; next cycle with LW_Stall=0 returns to defaults.
- MULDIV_CYCLES=4; MulDiv_Start held high 4 cycles -> MulDiv_Busy=1 and EX_MEM_Bubble=1 on cycles 0-2, MulDiv_Done=1 on cycle 3, state RUN on cycle 4.
- Branch_EX=1, LW_Stall=1, Jump_ID=1 same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1.
- IRQ=1, IRQ_Enable=1 pulsed during MD_BUSY -> no IRQ_Ack until the first RUN cycle after MulDiv_Done, then IRQ_Ack=1 and Exc_Redirect=1 for exactly one cycle.
- reset=1 asserted on the second MD_BUSY cycle -> forced reset outputs; after deassert, state RUN and MulDiv_Busy=0 with MulDiv_Start=0.
- With HAZARD_PERF_CNT_EN: 3 load stalls plus 1 branch -> Stall_Cycles=3, Flush_Events=4.
